// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch queue's redirect, instruction-ROM and
// decode-side dequeue signals.
//   slave  : the fetch queue itself (drives imem_addr and the deq_* / status outputs)
//   master : the surrounding pipeline (drives redirect, imem_data, deq_ready)
// Signals:
//   redirect, redirect_pc    : flush and restart fetch at redirect_pc
//   imem_addr, imem_data     : combinational instruction ROM port
//   deq_ready, deq_valid     : head handshake with decode
//   deq_instr, deq_pc, deq_npc : head entry contents (npc = pc + 4)
//   count, full, empty       : occupancy
interface fetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              deq_ready;
  logic              deq_valid;
  logic [DATA_W-1:0] deq_instr;
  logic [31:0]       deq_pc;
  logic [31:0]       deq_npc;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport slave (
    input  redirect, redirect_pc, imem_data, deq_ready,
    output imem_addr, deq_valid, deq_instr, deq_pc, deq_npc, count, full, empty
  );

  modport master (
    output redirect, redirect_pc, imem_data, deq_ready,
    input  imem_addr, deq_valid, deq_instr, deq_pc, deq_npc, count, full, empty
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a DEPTH-entry circular queue.
// Fetches one word per cycle from a combinational ROM at fetch_pc, stores
// {instr, pc} entries and presents the oldest entry to decode. A redirect
// flushes the queue and restarts fetch at the word-aligned redirect_pc.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : fetch_queue_if.slave (ROM port, redirect, dequeue handshake, status)
module fetch_queue #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 9,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [31:0]       fetch_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];

  logic        head_valid;
  logic        do_deq;
  logic        do_enq;
  logic [31:0] head_pc;

  assign head_valid = (cnt != '0);
  assign do_deq     = head_valid && bus.deq_ready && !bus.redirect;
  // A full queue can still accept a word when the head leaves in the same cycle.
  assign do_enq     = !bus.redirect && ((cnt != DEPTH_CNT) || do_deq);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (do_enq) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_enq && !do_deq) begin
        cnt <= cnt + 1'b1;
      end else if (!do_enq && do_deq) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Storage is not reset; empty entries are masked at the outputs instead.
  always_ff @(posedge clk) begin
    if (reset && do_enq) begin
      instr_mem[wr_ptr] <= bus.imem_data;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  assign head_pc       = head_valid ? pc_mem[rd_ptr] : 32'h0;

  assign bus.imem_addr = fetch_pc[ADDR_W-1:0];
  assign bus.deq_valid = head_valid;
  assign bus.deq_instr = head_valid ? instr_mem[rd_ptr] : '0;
  assign bus.deq_pc    = head_pc;
  assign bus.deq_npc   = head_pc + 32'd4;
  assign bus.count     = cnt;
  assign bus.full      = (cnt == DEPTH_CNT);
  assign bus.empty     = !head_valid;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mon_pc;

  always #5 clk = ~clk;

  fetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // ROM model: word at each address is 0xA0000000 | address.
  assign bus.imem_data = 32'hA000_0000 | 32'(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted head entry must match the next expected PC.
  always @(negedge clk) begin
    if (reset && !bus.redirect && bus.deq_valid && bus.deq_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_deq: got pc 0x%08h expected no dequeue", bus.deq_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        chk("sb_pc", bus.deq_pc, mon_pc);
        chk("sb_npc", bus.deq_npc, mon_pc + 32'd4);
        chk("sb_instr", bus.deq_instr, 32'hA000_0000 | {23'd0, mon_pc[8:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt;
    logic [31:0] nxt;
    bit rdy;

    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.deq_ready   = 1'b0;
    reset           = 1'b0;

    // Reset held for two cycles
    step();
    step();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_valid", 32'(bus.deq_valid), 32'd0);
    chk("rst_instr", bus.deq_instr, 32'd0);
    chk("rst_pc", bus.deq_pc, 32'd0);
    chk("rst_npc", bus.deq_npc, 32'd4);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);

    // Streaming with deq_ready held high
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    reset = 1'b1;
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_count", 32'(bus.count), 32'd1);
      chk("stream_pc", bus.deq_pc, 32'(i * 4));
    end
    step();
    bus.deq_ready = 1'b0;
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Fill and drain
    reset = 1'b0;
    step();
    chk("fill_rst_count", 32'(bus.count), 32'd0);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_full", 32'(bus.full), (i == 4) ? 32'd1 : 32'd0);
      chk("fill_empty", 32'(bus.empty), 32'd0);
    end
    chk("fill_imem_addr", 32'(bus.imem_addr), 32'd16);
    step();
    chk("full_hold_count", 32'(bus.count), 32'd4);
    chk("full_hold_imem_addr", 32'(bus.imem_addr), 32'd16);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_count", 32'(bus.count), 32'd4);
      chk("drain_pc", bus.deq_pc, 32'(i * 4));
      step();
    end
    bus.deq_ready = 1'b0;
    chk("drain_drained", 32'(exp_q.size()), 32'd0);
    chk("drain_full", 32'(bus.full), 32'd1);
    chk("drain_head", bus.deq_pc, 32'd32);

    // Redirect while full, with a head handshake that must be discarded
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    bus.deq_ready   = 1'b1;
    step();
    bus.redirect  = 1'b0;
    bus.deq_ready = 1'b0;
    chk("redir_count", 32'(bus.count), 32'd0);
    chk("redir_valid", 32'(bus.deq_valid), 32'd0);
    chk("redir_empty", 32'(bus.empty), 32'd1);
    chk("redir_imem_addr", 32'(bus.imem_addr), 32'h100);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    step();
    chk("redir_valid2", 32'(bus.deq_valid), 32'd1);
    chk("redir_pc", bus.deq_pc, 32'h100);
    chk("redir_npc", bus.deq_npc, 32'h104);
    chk("redir_instr", bus.deq_instr, 32'hA000_0100);
    bus.deq_ready = 1'b1;
    step();
    step();
    step();
    bus.deq_ready = 1'b0;
    chk("redir_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation
    step();
    step();
    chk("mid_count", 32'(bus.count), 32'd3);
    reset = 1'b0;
    step();
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_valid", 32'(bus.deq_valid), 32'd0);
    chk("mid_rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("mid_rst_npc", bus.deq_npc, 32'd4);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    reset = 1'b1;
    bus.deq_ready = 1'b1;
    step();
    chk("mid_restart_pc0", bus.deq_pc, 32'd0);
    step();
    chk("mid_restart_pc4", bus.deq_pc, 32'd4);
    step();
    bus.deq_ready = 1'b0;
    chk("mid_drained", 32'(exp_q.size()), 32'd0);

    // Wrap-around: alternate deq_ready for 3*DEPTH cycles
    exp_cnt = 1;
    nxt = 32'd8;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      rdy = (i % 2 == 0);
      bus.deq_ready = rdy;
      if (rdy) begin
        exp_q.push_back(nxt);
        nxt = nxt + 32'd4;
      end
      chk("wrap_count", 32'(bus.count), 32'(exp_cnt));
      chk("wrap_count_le_depth", 32'(bus.count <= 3'(DEPTH)), 32'd1);
      chk("wrap_full_empty_excl", 32'(bus.full & bus.empty), 32'd0);
      step();
      if (!rdy && exp_cnt < DEPTH) exp_cnt++;
    end
    bus.deq_ready = 1'b0;
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);
    chk("wrap_head", bus.deq_pc, nxt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL take the following parameters:
- DATA_W, 32, instruction word width.
- ADDR_W, 9, instruction-memory address width.
- DEPTH, 4, number of queue entries; a power of two, at least 2.
- RESET_PC, 0, fetch address after reset; a 32-bit value.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-low reset; asserted when 0.
- redirect, in, 1: flush the queue and restart fetch at redirect_pc (branch, call or jmpl resolution).
- redirect_pc, in, 32: new fetch address.
- imem_addr, out, ADDR_W: address to the combinational instruction ROM.
- imem_data, in, DATA_W: ROM word for imem_addr, valid in the same cycle.
- deq_ready, in, 1: decode accepts the head entry; equals not-stall.
- deq_valid, out, 1: head entry is valid.
- deq_instr, out, DATA_W: head instruction.
- deq_pc, out, 32: head PC.
- deq_npc, out, 32: head PC + 4.
- count, out, clog2(DEPTH+1): number of occupied entries.
- full, out, 1: count equals DEPTH.
- empty, out, 1: count equals 0.

Function
REQ-003 The block SHALL hold a 32-bit fetch_pc register and drive imem_addr = fetch_pc[ADDR_W-1:0] combinationally.

REQ-004 The queue SHALL be a circular buffer of DEPTH entries, each holding {instr, pc}, with read and write pointers that wrap modulo DEPTH.

REQ-005 Enqueue SHALL occur on a clock edge when redirect=0 and (count<DEPTH, or deq_valid=1 and deq_ready=1).

REQ-006 On enqueue, the entry SHALL be {imem_data, fetch_pc}, and fetch_pc SHALL advance by 4, wrapping modulo 2^32.

REQ-007 When no enqueue occurs and redirect=0, fetch_pc and imem_addr SHALL hold.

REQ-008 Dequeue SHALL occur on a clock edge when deq_valid=1, deq_ready=1 and redirect=0; deq_ready SHALL be ignored while the queue is empty.

REQ-009 Simultaneous enqueue and dequeue SHALL leave count unchanged, including when the queue is full.

REQ-010 deq_valid SHALL equal !empty. deq_instr and deq_pc SHALL show the head entry. deq_npc SHALL equal deq_pc+4.

REQ-011 When the queue is empty, deq_instr and deq_pc SHALL be 0 and deq_npc SHALL be 4.

REQ-012 There SHALL be no bypass: a word fetched at edge N is visible at the head no earlier than the cycle after edge N.

REQ-013 Steady-state throughput SHALL be one instruction per cycle with deq_ready held at 1.

REQ-014 On redirect=1 at an edge, redirect SHALL take priority over all other actions:
- both pointers reset and count becomes 0;
- fetch_pc loads {redirect_pc[31:2], 2'b00};
- no enqueue occurs, and any head handshake in that cycle is discarded.

REQ-015 After a redirect at edge N, deq_valid SHALL be 0 in cycle N+1 and 1 in cycle N+2, with deq_pc equal to the aligned redirect_pc.

REQ-016 Entries SHALL leave the queue in strict fetch order, with no duplication or loss across wrap-around of either pointer.

REQ-017 full and empty SHALL be derived from count and SHALL never both be 1.

Reset
REQ-018 While reset=0 at an edge, the block SHALL set count=0, both pointers=0 and fetch_pc=RESET_PC, and SHALL ignore redirect and deq_ready.

REQ-019 After a reset edge, deq_valid=0, empty=1, full=0, deq_instr=0, deq_pc=0, deq_npc=4 and imem_addr=RESET_PC[ADDR_W-1:0].

REQ-020 Reset asserted mid-operation SHALL discard all queued entries, with no entry surviving into the cycle after the reset edge.

REQ-021 The first enqueue SHALL occur on the first edge with reset=1.

Verification
REQ-022 The bench SHALL use a ROM model whose word at each address equals 0xA0000000 | address, and SHALL cover the following directed scenarios:
- Reset: hold reset=0 for 2 cycles -> count=0, empty=1, deq_valid=0, deq_npc=4, imem_addr=0.
- Streaming: release reset with deq_ready=1 -> from cycle 1, deq_pc=0,4,8,12 on consecutive cycles, deq_instr=0xA0000000|pc, count stays 1.
- Fill and drain (DEPTH=4): deq_ready=0 from reset release -> count=1,2,3,4, full=1 at cycle 4, imem_addr held at 16. Then deq_ready=1 -> deq_pc=0,4,8,12,16,... with no gap, count stays 4.
- Redirect while full: redirect=1, redirect_pc=0x103 -> next cycle count=0, deq_valid=0. The cycle after, deq_pc=0x100, deq_npc=0x104, deq_instr=0xA0000100.
- Reset mid-operation: count=3, then reset=0 for 1 cycle -> count=0, fetch_pc=RESET_PC. After release, deq_pc restarts at 0.
- Wrap-around: alternate deq_ready 1/0 for 3*DEPTH cycles -> deq_pc sequence strictly increasing by 4 and count never exceeds DEPTH.
